// File: rtl/core_pkg.sv
// Shared core types: fetch FSM encoding, trap cause codes, NOP and the fetch slot record.
package core_pkg;

  localparam logic [31:0] NOP_INST_C = 32'h0000_0013;

  localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_IACCESS   = 4'd1;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic [3:0]  cause;
  } slot_t;

endpackage

// File: rtl/fetch_slot.sv
// Single-entry instruction register between fetch and decode, valid/ready handshake.
module fetch_slot
  import core_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        load_i,
  input  slot_t       wdata_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  output logic [3:0]  cause_o
);

  slot_t slot_q, slot_d;
  logic  valid_q, valid_d;

  // Flush beats load: a redirect in the same cycle as a response discards it.
  always_comb begin
    valid_d = valid_q;
    slot_d  = slot_q;
    if (flush_i || (!load_i && valid_q && ready_i)) begin
      valid_d      = 1'b0;
      slot_d.inst  = NOP_INST;
      slot_d.fault = 1'b0;
      slot_d.cause = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      slot_d  = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      slot_q  <= '{inst: NOP_INST, pc: '0, fault: 1'b0, cause: '0};
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = slot_q.inst;
  assign pc_o    = slot_q.pc;
  assign fault_o = slot_q.fault;
  assign cause_o = slot_q.cause;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC, one-outstanding imem request FSM, redirect flush and fetch faults.
module inst_fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = NOP_INST_C
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic [3:0]  fault_cause
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         slot_free, misaligned, granted, outstanding, slot_load;
  slot_t        slot_wdata;

  assign slot_free   = !inst_valid || inst_ready;
  assign misaligned  = (pc_q[1:0] != 2'b00);
  // State resets to REQ, so the request must also be gated by reset itself.
  assign imem_req    = rst_n && (state_q == ST_REQ) && slot_free && !misaligned;
  assign imem_addr   = pc_q;
  assign granted     = imem_req && imem_gnt;
  assign outstanding = granted ||
                       (((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem_rvalid);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    slot_load  = 1'b0;
    slot_wdata = '{inst: NOP_INST, pc: pc_q, fault: 1'b0, cause: CAUSE_IMISALIGN};
    case (state_q)
      ST_REQ: begin
        // A misaligned redirect target parks here one cycle, then reports the fault.
        if (misaligned) begin
          if (slot_free) begin
            slot_load        = 1'b1;
            slot_wdata.fault = 1'b1;
            slot_wdata.cause = CAUSE_IMISALIGN;
            state_d          = ST_HALT;
          end
        end else if (granted) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          slot_load = 1'b1;
          if (imem_err) begin
            slot_wdata.fault = 1'b1;
            slot_wdata.cause = CAUSE_IACCESS;
            state_d          = ST_HALT;
          end else begin
            slot_wdata.inst = imem_rdata;
            pc_d            = pc_q + 32'd4;
            state_d         = ST_REQ;
          end
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_d = ST_REQ;
      end
      ST_HALT: ;
    endcase

    if (redirect_valid) begin
      pc_d      = redirect_pc;
      slot_load = 1'b0;
      state_d   = outstanding ? ST_DROP : ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_slot #(.NOP_INST(NOP_INST)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .load_i  (slot_load),
    .wdata_i (slot_wdata),
    .ready_i (inst_ready),
    .valid_o (inst_valid),
    .inst_o  (inst_out),
    .pc_o    (inst_pc),
    .fault_o (inst_fault),
    .cause_o (fault_cause)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed vector table, hand sequences, randomized run vs stream model.
module tb_inst_fetch_unit;

  localparam logic        H   = 1'b1;
  localparam logic        L   = 1'b0;
  localparam logic [3:0]  C0  = 4'd0;
  localparam logic [3:0]  C1  = 4'd1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] I0  = 32'h0050_0093;
  localparam logic [31:0] I1  = 32'h00A0_0113;
  localparam logic [31:0] I2  = 32'h0640_0193;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam logic [31:0] Z   = 32'h0;

  logic        clk, rst_n;
  logic        imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst_out, inst_pc;
  logic [3:0]  fault_cause;

  int checks = 0;
  int failures = 0;

  inst_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_fault(inst_fault), .fault_cause(fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        err, redir;
    logic [31:0] rpc;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_out, e_pc;
    logic        e_fault;
    logic [3:0]  e_cause;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs are applied right after an edge; outputs are compared 1 time unit later, before the next edge.
  task automatic apply_row(input vec_t v, input string tag);
    imem_gnt = v.gnt; imem_rvalid = v.rvalid; imem_rdata = v.rdata; imem_err = v.err;
    redirect_valid = v.redir; redirect_pc = v.rpc; inst_ready = v.ready;
    #1;
    chk({tag, ".req"}, 32'(imem_req), 32'(v.e_req));
    if (v.e_req) chk({tag, ".addr"}, imem_addr, v.e_addr);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(v.e_valid));
    chk({tag, ".out"}, inst_out, v.e_out);
    if (v.e_valid) begin
      chk({tag, ".pc"}, inst_pc, v.e_pc);
      chk({tag, ".fault"}, 32'(inst_fault), 32'(v.e_fault));
      chk({tag, ".cause"}, 32'(fault_cause), 32'(v.e_cause));
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"}, 32'(imem_req), 32'd0);
    chk({tag, ".valid"}, 32'(inst_valid), 32'd0);
    chk({tag, ".out"}, inst_out, NOP);
    chk({tag, ".pc"}, inst_pc, 32'd0);
    chk({tag, ".fault"}, 32'(inst_fault), 32'd0);
    chk({tag, ".cause"}, 32'(fault_cause), 32'd0);
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  vec_t        tv[15];
  vec_t        hs[$];
  logic        m_pend, fire, stall_prev;
  int          m_cnt, n_cons;
  logic [31:0] m_addr, faddr, exp_pc;
  logic [31:0] sv_out, sv_pc;
  logic        sv_fault;
  logic [3:0]  sv_cause;

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; imem_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;

    // Fetch 0x0/0x4, 5-cycle decode stall, redirect to 0x100 with a stale response in flight.
    tv[0]  = '{H,L,Z,  L,L,Z,         H, H,Z,         L,NOP,Z,          L,C0};
    tv[1]  = '{L,H,I0, L,L,Z,         H, L,Z,         L,NOP,Z,          L,C0};
    tv[2]  = '{H,L,Z,  L,L,Z,         H, H,32'h4,     H,I0, Z,          L,C0};
    tv[3]  = '{L,H,I1, L,L,Z,         H, L,Z,         L,NOP,Z,          L,C0};
    for (int i = 4; i < 9; i++)
      tv[i] = '{H,L,Z, L,L,Z,         L, L,Z,         H,I1, 32'h4,      L,C0};
    tv[9]  = '{H,L,Z,  L,L,Z,         H, H,32'h8,     H,I1, 32'h4,      L,C0};
    tv[10] = '{L,L,Z,  L,H,32'h100,   H, L,Z,         L,NOP,Z,          L,C0};
    tv[11] = '{L,H,BAD,L,L,Z,         H, L,Z,         L,NOP,Z,          L,C0};
    tv[12] = '{H,L,Z,  L,L,Z,         H, H,32'h100,   L,NOP,Z,          L,C0};
    tv[13] = '{L,H,I2, L,L,Z,         H, L,Z,         L,NOP,Z,          L,C0};
    tv[14] = '{L,L,Z,  L,L,Z,         H, H,32'h104,   H,I2, 32'h100,    L,C0};

    @(posedge clk); #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) apply_row(tv[i], $sformatf("row%0d", i));

    // Misaligned redirect target, held fault, then recovery via aligned redirect.
    hs = {};
    hs.push_back('{L,L,Z,L,H,32'h102, H, H,32'h104, L,NOP,Z,       L,C0});
    hs.push_back('{H,L,Z,L,L,Z,       H, L,Z,       L,NOP,Z,       L,C0});
    hs.push_back('{H,L,Z,L,L,Z,       L, L,Z,       H,NOP,32'h102, H,C0});
    hs.push_back('{H,L,Z,L,L,Z,       H, L,Z,       H,NOP,32'h102, H,C0});
    hs.push_back('{H,L,Z,L,L,Z,       H, L,Z,       L,NOP,Z,       L,C0});
    hs.push_back('{L,L,Z,L,H,32'h200, H, L,Z,       L,NOP,Z,       L,C0});
    hs.push_back('{H,L,Z,L,L,Z,       H, H,32'h200, L,NOP,Z,       L,C0});
    foreach (hs[i]) apply_row(hs[i], $sformatf("mis%0d", i));

    // Reset asserted while WAIT; redirect during reset must be ignored.
    rst_n = 1'b0; imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; inst_ready = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk); #1;
    chk_reset_vals("rst_hold");
    rst_n = 1'b1; redirect_valid = 1'b0;

    // Access fault at 0x8, halt, spurious rvalid ignored, redirect resumes at 0x0.
    hs = {};
    hs.push_back('{H,L,Z,  L,L,Z, H, H,Z,     L,NOP,Z,     L,C0});
    hs.push_back('{L,H,I0, L,L,Z, H, L,Z,     L,NOP,Z,     L,C0});
    hs.push_back('{H,L,Z,  L,L,Z, H, H,32'h4, H,I0, Z,     L,C0});
    hs.push_back('{L,H,I1, L,L,Z, H, L,Z,     L,NOP,Z,     L,C0});
    hs.push_back('{H,L,Z,  L,L,Z, H, H,32'h8, H,I1, 32'h4, L,C0});
    hs.push_back('{L,H,BAD,H,L,Z, H, L,Z,     L,NOP,Z,     L,C0});
    hs.push_back('{H,L,Z,  L,L,Z, L, L,Z,     H,NOP,32'h8, H,C1});
    hs.push_back('{H,L,Z,  L,L,Z, H, L,Z,     H,NOP,32'h8, H,C1});
    hs.push_back('{H,L,Z,  L,L,Z, H, L,Z,     L,NOP,Z,     L,C0});
    hs.push_back('{H,H,BAD,L,L,Z, H, L,Z,     L,NOP,Z,     L,C0});
    hs.push_back('{H,L,Z,  L,L,Z, H, L,Z,     L,NOP,Z,     L,C0});
    hs.push_back('{L,L,Z,  L,H,Z, H, L,Z,     L,NOP,Z,     L,C0});
    hs.push_back('{H,L,Z,  L,L,Z, H, H,Z,     L,NOP,Z,     L,C0});
    foreach (hs[i]) apply_row(hs[i], $sformatf("err%0d", i));

    // Randomized run: the decoded stream must be memw(pc) for consecutive pcs, restarting at each redirect.
    rst_n = 1'b0; imem_rvalid = 1'b0; imem_err = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_pend = 1'b0; m_cnt = 0; m_addr = '0; exp_pc = 32'h0; n_cons = 0; stall_prev = 1'b0;
    sv_out = '0; sv_pc = '0; sv_fault = 1'b0; sv_cause = '0;
    for (int c = 0; c < 3000; c++) begin
      inst_ready     = ($urandom_range(0, 3) != 0);
      imem_gnt       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom() & 32'h0000_0FFC;
      #1;
      if (stall_prev) begin
        chk("stall.valid", 32'(inst_valid), 32'd1);
        chk("stall.out", inst_out, sv_out);
        chk("stall.pc", inst_pc, sv_pc);
        chk("stall.fault", 32'(inst_fault), 32'(sv_fault));
        chk("stall.cause", 32'(fault_cause), 32'(sv_cause));
      end
      chk("rand.req_when_full", 32'(imem_req && inst_valid && !inst_ready), 32'd0);
      if (inst_valid && inst_ready && !redirect_valid) begin
        chk("rand.pc", inst_pc, exp_pc);
        chk("rand.out", inst_out, memw(exp_pc));
        chk("rand.fault", 32'(inst_fault), 32'd0);
        exp_pc = exp_pc + 32'd4;
        n_cons++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      stall_prev = inst_valid && !inst_ready && !redirect_valid;
      sv_out = inst_out; sv_pc = inst_pc; sv_fault = inst_fault; sv_cause = fault_cause;
      fire  = imem_req && imem_gnt;
      faddr = imem_addr;
      @(posedge clk); #1;
      imem_rvalid = 1'b0; imem_rdata = $urandom(); imem_err = 1'b0;
      if (fire) begin
        m_pend = 1'b1; m_cnt = $urandom_range(1, 3); m_addr = faddr;
      end
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1; imem_rdata = memw(m_addr); m_pend = 1'b0;
        end
      end
    end
    chk("rand.liveness", 32'(n_cons > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
